// File: rtl/bias_bram_lane_ctrl.sv
// Bias buffer controller: preloads per-channel biases into a single-port BRAM and serves them
// LANES at a time to the PE array. Optional macro BIAS_ZERO_PAD_EN zero-fills lanes past the layer end.
`timescale 1ns/1ps
module bias_bram_lane_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int LANES  = 4,
    parameter int RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [11:0]             cfg_ch_size,
    input  logic                    load_start,
    input  logic                    group_start,
    input  logic                    layer_finish,
    input  logic                    s_valid,
    input  logic [DATA_W-1:0]       s_data,
    output logic                    s_ready,
    output logic                    bram_en,
    output logic                    bram_we,
    output logic [ADDR_W-1:0]       bram_addr,
    output logic [DATA_W-1:0]       bram_wdata,
    input  logic [DATA_W-1:0]       bram_rdata,
    output logic [LANES*DATA_W-1:0] bias_out,
    output logic                    bias_valid,
    output logic                    load_done,
    output logic [2:0]              state_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_eff;
    logic [31:0]        cfg_ext;
    logic [ADDR_W-1:0]  wr_cnt, rd_ptr, rd_ptr_adv;
    logic [IDX_W-1:0]   iss_idx;
    logic [LANES*DATA_W-1:0] bias_q;

    // Read-tag pipeline: valid bits are reset, the payload rides along unqualified.
    logic               tag_v   [RD_LAT];
    logic [IDX_W-1:0]   tag_idx [RD_LAT];
    logic               tag_z   [RD_LAT];

    logic s_fire, last_wr, last_iss, last_tag, flush, iss_pad;

    // Layer size is clamped to the BRAM depth.
    assign cfg_ext = 32'(cfg_ch_size);
    assign n_eff   = (cfg_ext > 32'(DEPTH)) ? CNT_W'(DEPTH) : CNT_W'(cfg_ext);

    assign s_fire   = (state_q == S_LOAD) && s_valid;
    assign last_wr  = s_fire && (wr_cnt == ADDR_W'(n_q - CNT_W'(1)));
    assign last_iss = (state_q == S_ISSUE) && (iss_idx == IDX_W'(LANES - 1));
    assign last_tag = tag_v[RD_LAT-1] && (tag_idx[RD_LAT-1] == IDX_W'(LANES - 1));
    assign flush    = layer_finish &&
                      (state_q == S_ISSUE || state_q == S_DRAIN || state_q == S_HOLD);

    assign rd_ptr_adv = ((32'(rd_ptr) + 32'(LANES)) >= 32'(n_q)) ? '0
                                                                   : rd_ptr + ADDR_W'(LANES);

`ifdef BIAS_ZERO_PAD_EN
    assign iss_pad = (32'(rd_ptr) + 32'(iss_idx)) >= 32'(n_q);
`else
    assign iss_pad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        s_ready    = 1'b0;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (load_start && n_eff != '0) state_d = S_LOAD;
                else if (group_start)          state_d = S_ISSUE;
            end
            S_LOAD: begin
                s_ready    = 1'b1;
                bram_en    = s_valid;
                bram_we    = s_valid;
                bram_addr  = wr_cnt;
                bram_wdata = s_data;
                if (last_wr) state_d = S_IDLE;
            end
            S_ISSUE: begin
                bram_en   = !iss_pad;
                bram_addr = rd_ptr + ADDR_W'(iss_idx);
                if (flush)         state_d = S_IDLE;
                else if (last_iss) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (flush)         state_d = S_IDLE;
                else if (last_tag) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (flush)            state_d = S_IDLE;
                else if (group_start) state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= '0;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            iss_idx   <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= last_wr;
            if (state_q == S_IDLE && state_d != S_IDLE) n_q <= n_eff;

            if (state_q == S_IDLE && state_d == S_LOAD) wr_cnt <= '0;
            else if (s_fire)                            wr_cnt <= wr_cnt + 1'b1;

            // A fresh load or an aborted layer both restart at channel 0.
            if (flush || (state_q == S_IDLE && state_d == S_LOAD)) rd_ptr <= '0;
            else if (last_iss)                                     rd_ptr <= rd_ptr_adv;

            if (state_q == S_ISSUE && state_d == S_ISSUE) iss_idx <= iss_idx + 1'b1;
            else                                         iss_idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LAT; s++) tag_v[s] <= 1'b0;
        end else if (flush) begin
            for (int s = 0; s < RD_LAT; s++) tag_v[s] <= 1'b0;
        end else begin
            tag_v[0] <= (state_q == S_ISSUE);
            for (int s = 1; s < RD_LAT; s++) tag_v[s] <= tag_v[s-1];
        end
    end

    // NOTE: tag payload needs no reset; it is only ever consumed alongside a reset-cleared tag_v.
    always_ff @(posedge clk) begin
        tag_idx[0] <= iss_idx;
        tag_z[0]   <= iss_pad;
        for (int s = 1; s < RD_LAT; s++) begin
            tag_idx[s] <= tag_idx[s-1];
            tag_z[s]   <= tag_z[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else if (tag_v[RD_LAT-1] && !flush) begin
            bias_q[32'(tag_idx[RD_LAT-1]) * DATA_W +: DATA_W] <=
                tag_z[RD_LAT-1] ? '0 : bram_rdata;
        end
    end

    assign bias_out   = bias_q;
    assign bias_valid = (state_q == S_HOLD);
    assign state_o    = state_q;

endmodule

// File: tb/tb_bias_bram_lane_ctrl.sv
// Directed bench for bias_bram_lane_ctrl with a behavioural BRAM and a scoreboard of expected
// bias groups. Honours BIAS_ZERO_PAD_EN when defined.
`timescale 1ns/1ps
module tb_bias_bram_lane_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int LN    = 4;
    localparam int RL    = 2;
    localparam int LW    = LN * DW;
    localparam int DEPTH = 2 ** AW;
    localparam int GRP_LAT = LN + RL + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   cfg_ch_size;
    logic          load_start, group_start, layer_finish;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata, bram_rdata;
    logic [LW-1:0] bias_out;
    logic          bias_valid, load_done;
    logic [2:0]    state_o;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_mem [DEPTH];
    logic [LW-1:0] sb [$];
    int            ptr = 0;
    int            n_cur = 0;

    bias_bram_lane_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_ch_size(cfg_ch_size),
        .load_start(load_start), .group_start(group_start), .layer_finish(layer_finish),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .bias_out(bias_out), .bias_valid(bias_valid), .load_done(load_done),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Behavioural single-port BRAM with RL-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
        if (bram_en && !bram_we) rd_pipe[0] <= mem[bram_addr];
        for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bram_rdata = rd_pipe[RL-1];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int n, input logic [DW-1:0] base, input bit toggle);
        int k;
        int cyc;
        cfg_ch_size = 12'(n);
        load_start  = 1'b1;
        tick();
        load_start = 1'b0;
        n_cur = (n > DEPTH) ? DEPTH : n;
        ptr   = 0;
        k     = 0;
        cyc   = 0;
        while (k < n_cur && cyc < 200) begin
            s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            s_data  = base + DW'(k);
            #1;
            check("load_s_ready", s_ready, 1'b1);
            check("load_we", bram_we, s_valid);
            check("load_done_early", load_done, 1'b0);
            if (s_valid) begin
                check("load_addr", bram_addr, AW'(k));
                check("load_wdata", bram_wdata, base + DW'(k));
                exp_mem[k] = base + DW'(k);
                k++;
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        check("load_done_pulse", load_done, 1'b1);
        check("load_s_ready_after", s_ready, 1'b0);
        check("load_state_idle", state_o, 3'd0);
        tick();
        check("load_done_clear", load_done, 1'b0);
    endtask

    task automatic do_group(input bit hold_chk);
        logic [LW-1:0] ev;
        logic [LN-1:0] exp_en;
        logic [LN-1:0] en_mask;
        logic [DW-1:0] w;
        int            ch;
        int            cnt;
        for (int i = 0; i < LN; i++) begin
            ch = ptr + i;
            exp_en[i] = 1'b1;
            if (ch < n_cur) begin
                w = exp_mem[ch];
            end else begin
`ifdef BIAS_ZERO_PAD_EN
                w = '0;
                exp_en[i] = 1'b0;
`else
                w = exp_mem[ch % DEPTH];
`endif
            end
            ev[i*DW +: DW] = w;
        end
        sb.push_back(ev);

        group_start = 1'b1;
        tick();
        group_start = 1'b0;
        check("grp_state_issue", state_o, 3'd2);
        check("grp_valid_drop", bias_valid, 1'b0);
        cnt     = 1;
        en_mask = '0;
        while (!bias_valid && cnt < 40) begin
            if (cnt <= LN) begin
                en_mask[cnt-1] = bram_en;
                check("issue_we", bram_we, 1'b0);
                if (bram_en) check("issue_addr", bram_addr, AW'((ptr + cnt - 1) % DEPTH));
            end
            tick();
            cnt++;
        end
        check("grp_latency", cnt, GRP_LAT);
        check("issue_en_mask", en_mask, exp_en);
        if (sb.size() == 0) begin
            check("sb_nonempty", 1'b0, 1'b1);
        end else begin
            ev = sb.pop_front();
            check("bias_out", bias_valid ? bias_out : 'x, ev);
        end
        if (hold_chk) begin
            tick();
            tick();
            check("hold_valid", bias_valid, 1'b1);
            check("hold_state", state_o, 3'd4);
            check("hold_stable", bias_out, ev);
        end
        ptr = (ptr + LN >= n_cur) ? 0 : ptr + LN;
    endtask

    initial begin
        int ld_seen;
        rst_n        = 1'b0;
        cfg_ch_size  = '0;
        load_start   = 1'b0;
        group_start  = 1'b0;
        layer_finish = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        for (int s = 0; s < RL; s++) rd_pipe[s] = '0;
        #3;
        check("rst_state", state_o, 3'd0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_bram_en", bram_en, 1'b0);
        check("rst_bram_we", bram_we, 1'b0);
        check("rst_bram_addr", bram_addr, '0);
        check("rst_bram_wdata", bram_wdata, '0);
        check("rst_bias_out", bias_out, '0);
        check("rst_bias_valid", bias_valid, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Eight-channel layer, continuous stream.
        do_load(8, 32'h100, 1'b0);
        for (int a = 0; a < 8; a++) check("mem_after_load", mem[a], 32'h100 + DW'(a));
        do_group(1'b1);
        do_group(1'b0);
        do_group(1'b0);

        // layer_finish beats a simultaneous group_start in HOLD.
        group_start  = 1'b1;
        layer_finish = 1'b1;
        tick();
        group_start  = 1'b0;
        layer_finish = 1'b0;
        check("lf_hold_state", state_o, 3'd0);
        check("lf_hold_valid", bias_valid, 1'b0);
        ptr = 0;

        // Six-channel layer with a 1-0-1 valid pattern; second group runs past the layer end.
        do_load(6, 32'h100, 1'b1);
        do_group(1'b0);
        do_group(1'b0);
        do_group(1'b0);

        // Abort in DRAIN.
        group_start = 1'b1;
        tick();
        group_start = 1'b0;
        for (int c = 0; c < LN; c++) tick();
        check("drain_state", state_o, 3'd3);
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        check("lf_drain_state", state_o, 3'd0);
        check("lf_drain_valid", bias_valid, 1'b0);
        for (int c = 0; c < 6; c++) tick();
        check("lf_drain_valid_later", bias_valid, 1'b0);
        ptr = 0;
        do_group(1'b0);

        // Zero-size load is ignored.
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        ptr = 0;
        cfg_ch_size = '0;
        load_start  = 1'b1;
        tick();
        load_start = 1'b0;
        check("zero_load_state", state_o, 3'd0);
        check("zero_load_s_ready", s_ready, 1'b0);
        ld_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (load_done) ld_seen++;
            tick();
        end
        check("zero_load_no_done", ld_seen, 0);
        cfg_ch_size = 12'd6;

        // Asynchronous reset in the middle of ISSUE.
        group_start = 1'b1;
        tick();
        group_start = 1'b0;
        tick();
        check("pre_rst_issue", state_o, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state_o, 3'd0);
        check("arst_bram_en", bram_en, 1'b0);
        check("arst_bram_addr", bram_addr, '0);
        check("arst_bias_out", bias_out, '0);
        check("arst_bias_valid", bias_valid, 1'b0);
        check("arst_s_ready", s_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        ptr = 0;
        do_group(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
